accdec_seq: RTL and testbench

- Parametrised, registered successor to the accumulator-control decoder.
- Accepts opcodes from fetch through a valid/ready handshake and emits a registered 3-bit accumulator control word.
- Stalls fetch for multi-cycle memory ops and post-jump bubbles; flags and counts illegal opcodes.
- Sits between instruction fetch and the accumulator/datapath control.

---
 rtl/accdec_pkg.sv | 35 +++
 rtl/accdec_if.sv | 25 ++
 rtl/accdec_comb.sv | 70 +++++++
 rtl/accdec_seq.sv | 118 +++++++++++
 tb/tb_accdec_seq.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/accdec_pkg.sv
// Shared definitions for the accumulator-control decoder: control codes,
// opcode class encodings and the sequencer state type.
package accdec_pkg;

  localparam logic [2:0] ACC_NONE  = 3'b000;
  localparam logic [2:0] ACC_ALU   = 3'b001;
  localparam logic [2:0] ACC_UNARY = 3'b010;
  localparam logic [2:0] ACC_EQ    = 3'b011;
  localparam logic [2:0] ACC_JMP   = 3'b100;
  localparam logic [2:0] ACC_STORE = 3'b101;
  localparam logic [2:0] ACC_LOAD  = 3'b110;
  localparam logic [2:0] ACC_LDI   = 3'b111;

  localparam logic [2:0] CLS_BASIC = 3'b000;
  localparam logic [2:0] CLS_MEM   = 3'b001;
  localparam logic [2:0] CLS_ALU   = 3'b010;
  localparam logic [2:0] CLS_RSV   = 3'b011;
  localparam logic [2:0] CLS_EQ    = 3'b100;
  localparam logic [2:0] CLS_LDI   = 3'b101;
  localparam logic [2:0] CLS_JR    = 3'b110;
  localparam logic [2:0] CLS_JMP   = 3'b111;

  localparam logic [2:0] SUB_LOAD  = 3'b000;
  localparam logic [2:0] SUB_STORE = 3'b001;

  // Hold/flush countdown width; MEM_LAT and JMP_FLUSH must fit in it.
  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEMWAIT = 2'd1,
    JFLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/accdec_if.sv
// Fetch-to-decoder handshake plus the registered accumulator control bundle.
interface accdec_if #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 8
);
  logic             flush;
  logic             op_valid;
  logic [OP_W-1:0]  op;
  logic             op_ready;
  logic             ctrl_valid;
  logic [2:0]       acc_ctrl;
  logic             mem_last;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output flush, op_valid, op,
    input  op_ready, ctrl_valid, acc_ctrl, mem_last, illegal, illegal_cnt
  );

  modport slave (
    input  flush, op_valid, op,
    output op_ready, ctrl_valid, acc_ctrl, mem_last, illegal, illegal_cnt
  );
endinterface

// File: rtl/accdec_comb.sv
// Pure combinational opcode decode: class/sub-op to control code plus
// memory, jump and illegal qualifiers.
module accdec_comb
  import accdec_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output logic [2:0]      acc_ctrl,
  output logic            is_mem,
  output logic            is_jmp,
  output logic            is_illegal
);

  logic [2:0] cls;
  logic [2:0] sub;
  logic       mid_nz;

  assign cls = op[OP_W-1:OP_W-3];
  assign sub = op[2:0];

  // Padding bits between class and sub-op exist only for OP_W > 6.
  if (OP_W > 6) begin : g_mid
    assign mid_nz = |op[OP_W-4:3];
  end else begin : g_nomid
    assign mid_nz = 1'b0;
  end

  always_comb begin
    acc_ctrl   = ACC_NONE;
    is_mem     = 1'b0;
    is_jmp     = 1'b0;
    is_illegal = 1'b0;
    case (cls)
      CLS_BASIC: begin
        if (!sub[2])                         acc_ctrl = ACC_ALU;
        else if (sub == 3'd5 || sub == 3'd6) acc_ctrl = ACC_UNARY;
        else                                 is_illegal = 1'b1;
      end
      CLS_MEM: begin
        if (sub == SUB_LOAD) begin
          acc_ctrl = ACC_LOAD;
          is_mem   = 1'b1;
        end else if (sub == SUB_STORE) begin
          acc_ctrl = ACC_STORE;
          is_mem   = 1'b1;
        end else begin
          is_illegal = 1'b1;
        end
      end
      CLS_ALU: acc_ctrl = ACC_ALU;
      CLS_RSV: is_illegal = 1'b1;
      CLS_EQ:  acc_ctrl = ACC_EQ;
      CLS_LDI: acc_ctrl = ACC_LDI;
      CLS_JR:  acc_ctrl = ACC_UNARY;
      CLS_JMP: begin
        acc_ctrl = ACC_JMP;
        is_jmp   = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
    if (mid_nz) begin
      acc_ctrl   = ACC_NONE;
      is_mem     = 1'b0;
      is_jmp     = 1'b0;
      is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/accdec_seq.sv
// Registered accumulator-control decoder: valid/ready intake, memory-hold and
// post-jump stall sequencing, illegal-op flag and saturating counter.
module accdec_seq
  import accdec_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int MEM_LAT   = 2,
  parameter int JMP_FLUSH = 1,
  parameter int CNT_W     = 8
) (
  input  logic      clk,
  input  logic      reset,
  accdec_if.slave   bus
);

  localparam logic [HOLD_W-1:0] MEM_INIT   = HOLD_W'(MEM_LAT);
  localparam logic [HOLD_W-1:0] JMP_INIT   = HOLD_W'((JMP_FLUSH > 0) ? JMP_FLUSH - 1 : 0);
  localparam bit                USE_JFLUSH = (JMP_FLUSH > 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [2:0]        dec_ctrl;
  logic              dec_mem;
  logic              dec_jmp;
  logic              dec_ill;
  logic              accept;
  state_t            state;
  logic [HOLD_W-1:0] cnt;
  logic              ctrl_valid_q;
  logic [2:0]        acc_ctrl_q;
  logic              illegal_q;
  logic [CNT_W-1:0]  illegal_cnt_q;

  accdec_comb #(.OP_W(OP_W)) u_comb (
    .op         (bus.op),
    .acc_ctrl   (dec_ctrl),
    .is_mem     (dec_mem),
    .is_jmp     (dec_jmp),
    .is_illegal (dec_ill)
  );

  assign bus.op_ready = (state == IDLE);
  assign accept       = bus.op_valid && bus.op_ready && !bus.flush;

  // Flush outranks every transition but deliberately leaves the counter alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      ctrl_valid_q  <= 1'b0;
      acc_ctrl_q    <= ACC_NONE;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else if (bus.flush) begin
      state        <= IDLE;
      cnt          <= '0;
      ctrl_valid_q <= 1'b0;
      acc_ctrl_q   <= ACC_NONE;
      illegal_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          illegal_q <= accept && dec_ill;
          if (accept) begin
            ctrl_valid_q <= 1'b1;
            acc_ctrl_q   <= dec_ctrl;
            if (dec_ill) illegal_cnt_q <= sat_inc(illegal_cnt_q);
            if (dec_mem) begin
              state <= MEMWAIT;
              cnt   <= MEM_INIT;
            end else if (dec_jmp && USE_JFLUSH) begin
              state <= JFLUSH;
              cnt   <= JMP_INIT;
            end
          end else begin
            ctrl_valid_q <= 1'b0;
            acc_ctrl_q   <= ACC_NONE;
          end
        end
        MEMWAIT: begin
          // Control word stays presented for the whole hold window.
          illegal_q <= 1'b0;
          if (cnt == '0) begin
            state        <= IDLE;
            ctrl_valid_q <= 1'b0;
            acc_ctrl_q   <= ACC_NONE;
          end else begin
            cnt <= cnt - HOLD_W'(1);
          end
        end
        JFLUSH: begin
          // Jump was shown on the accept cycle; remaining cycles are bubbles.
          illegal_q    <= 1'b0;
          ctrl_valid_q <= 1'b0;
          acc_ctrl_q   <= ACC_NONE;
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - HOLD_W'(1);
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          ctrl_valid_q <= 1'b0;
          acc_ctrl_q   <= ACC_NONE;
          illegal_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ctrl_valid  = ctrl_valid_q;
  assign bus.acc_ctrl    = acc_ctrl_q;
  assign bus.illegal     = illegal_q;
  assign bus.illegal_cnt = illegal_cnt_q;
  assign bus.mem_last    = (state == MEMWAIT) && (cnt == '0);

endmodule

// File: tb/tb_accdec_seq.sv
// Scoreboard bench for accdec_seq: a 6-bit/8-bit-counter instance for the main
// sequencing and an 8-bit/2-bit-counter instance for wide opcodes and saturation.
module tb_accdec_seq;
  import accdec_pkg::*;

  typedef struct packed {
    logic [2:0] acc;
    logic       ill;
    logic       ml;
    logic [7:0] cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  logic [7:0] cnt_a = 8'd0;

  logic [5:0] bb_op  [3] = '{6'b000001, 6'b010011, 6'b100000};
  logic [2:0] bb_acc [3] = '{3'b001, 3'b001, 3'b011};
  logic [5:0] ill_a  [3] = '{6'b000100, 6'b011000, 6'b001010};
  logic [7:0] op_b   [6] = '{8'b00000100, 8'b01100000, 8'b00100010,
                             8'b00001000, 8'b01100000, 8'b01000011};
  logic [2:0] acc_b  [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
  logic       ill_b  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] cnt_b  [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};

  accdec_if #(.OP_W(6), .CNT_W(8)) ia ();
  accdec_if #(.OP_W(8), .CNT_W(2)) ib ();

  accdec_seq #(.OP_W(6), .MEM_LAT(2), .JMP_FLUSH(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(ia)
  );
  accdec_seq #(.OP_W(8), .MEM_LAT(2), .JMP_FLUSH(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ib)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [2:0] a, input logic il, input logic ml,
                              input logic [7:0] c);
    return {a, il, ml, c};
  endfunction

  always @(negedge clk) begin
    if (!reset && ia.ctrl_valid === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_output: acc_ctrl=%0h with no expected entry at %0t",
                 ia.acc_ctrl, $time);
      end else begin
        ea = qa.pop_front();
        chk("a_acc_ctrl", 32'(ia.acc_ctrl), 32'(ea.acc));
        chk("a_illegal", 32'(ia.illegal), 32'(ea.ill));
        chk("a_mem_last", 32'(ia.mem_last), 32'(ea.ml));
        chk("a_illegal_cnt", 32'(ia.illegal_cnt), 32'(ea.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ib.ctrl_valid === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_output: acc_ctrl=%0h with no expected entry at %0t",
                 ib.acc_ctrl, $time);
      end else begin
        eb = qb.pop_front();
        chk("b_acc_ctrl", 32'(ib.acc_ctrl), 32'(eb.acc));
        chk("b_illegal", 32'(ib.illegal), 32'(eb.ill));
        chk("b_illegal_cnt", 32'(ib.illegal_cnt), 32'(eb.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ia.flush = 1'b0; ia.op_valid = 1'b0; ia.op = '0;
    ib.flush = 1'b0; ib.op_valid = 1'b0; ib.op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_valid", 32'(ia.ctrl_valid), 0);
    chk("a_rst_acc", 32'(ia.acc_ctrl), 0);
    chk("a_rst_illegal", 32'(ia.illegal), 0);
    chk("a_rst_cnt", 32'(ia.illegal_cnt), 0);
    chk("a_rst_mem_last", 32'(ia.mem_last), 0);
    chk("a_rst_ready", 32'(ia.op_ready), 1);
    chk("b_rst_cnt", 32'(ib.illegal_cnt), 0);
    chk("b_rst_ready", 32'(ib.op_ready), 1);
    reset = 1'b0;
    tick();

    // Reset arriving asynchronously in the middle of a memory hold.
    ia.op_valid = 1'b1; ia.op = 6'b001000;
    tick();
    ia.op_valid = 1'b0;
    chk("a_mw_acc", 32'(ia.acc_ctrl), 32'(ACC_LOAD));
    chk("a_mw_ready", 32'(ia.op_ready), 0);
    #1 reset = 1'b1;
    #1;
    chk("a_async_rst_valid", 32'(ia.ctrl_valid), 0);
    chk("a_async_rst_acc", 32'(ia.acc_ctrl), 0);
    chk("a_async_rst_mem_last", 32'(ia.mem_last), 0);
    chk("a_async_rst_ready", 32'(ia.op_ready), 1);
    tick();
    reset = 1'b0;
    tick();

    // Back-to-back single-cycle ops.
    ia.op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ia.op = bb_op[i];
      qa.push_back(mk(bb_acc[i], 1'b0, 1'b0, cnt_a));
      tick();
      chk("a_b2b_ready", 32'(ia.op_ready), 1);
      chk("a_b2b_valid", 32'(ia.ctrl_valid), 1);
    end
    ia.op_valid = 1'b0;
    tick();
    chk("a_idle_valid", 32'(ia.ctrl_valid), 0);

    // LOAD hold, then a STORE waiting with op_valid held.
    ia.op_valid = 1'b1; ia.op = 6'b001000;
    qa.push_back(mk(ACC_LOAD, 1'b0, 1'b0, cnt_a));
    qa.push_back(mk(ACC_LOAD, 1'b0, 1'b0, cnt_a));
    qa.push_back(mk(ACC_LOAD, 1'b0, 1'b1, cnt_a));
    tick();
    ia.op = 6'b001001;
    qa.push_back(mk(ACC_STORE, 1'b0, 1'b0, cnt_a));
    qa.push_back(mk(ACC_STORE, 1'b0, 1'b0, cnt_a));
    qa.push_back(mk(ACC_STORE, 1'b0, 1'b1, cnt_a));
    for (int i = 0; i < 3; i++) begin
      chk("a_load_ready_low", 32'(ia.op_ready), 0);
      chk("a_load_valid", 32'(ia.ctrl_valid), 1);
      tick();
    end
    chk("a_load_ready_back", 32'(ia.op_ready), 1);
    chk("a_load_gap_valid", 32'(ia.ctrl_valid), 0);
    tick();
    ia.op_valid = 1'b0;
    chk("a_store_accept_ready", 32'(ia.op_ready), 0);
    chk("a_store_acc", 32'(ia.acc_ctrl), 32'(ACC_STORE));
    repeat (3) tick();
    chk("a_store_done_ready", 32'(ia.op_ready), 1);

    // Jump with a one-cycle fetch stall.
    ia.op_valid = 1'b1; ia.op = 6'b111000;
    qa.push_back(mk(ACC_JMP, 1'b0, 1'b0, cnt_a));
    tick();
    chk("a_jmp_ready", 32'(ia.op_ready), 0);
    ia.op = 6'b000001;
    qa.push_back(mk(ACC_ALU, 1'b0, 1'b0, cnt_a));
    tick();
    chk("a_jmp_bubble_valid", 32'(ia.ctrl_valid), 0);
    chk("a_jmp_ready_back", 32'(ia.op_ready), 1);
    tick();
    chk("a_after_jmp_valid", 32'(ia.ctrl_valid), 1);
    ia.op_valid = 1'b0;
    tick();

    // Illegal opcodes on the narrow instance.
    ia.op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ia.op = ill_a[i];
      cnt_a = cnt_a + 8'd1;
      qa.push_back(mk(ACC_NONE, 1'b1, 1'b0, cnt_a));
      tick();
      chk("a_ill_ready", 32'(ia.op_ready), 1);
    end
    ia.op_valid = 1'b0;
    tick();
    chk("a_ill_flag_clear", 32'(ia.illegal), 0);
    chk("a_ill_cnt_hold", 32'(ia.illegal_cnt), 3);

    // Wide opcodes and counter saturation on the 2-bit-counter instance.
    ib.op_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ib.op = op_b[i];
      qb.push_back(mk(acc_b[i], ill_b[i], 1'b0, cnt_b[i]));
      tick();
    end
    ib.op_valid = 1'b0;
    tick();
    chk("b_sat_cnt", 32'(ib.illegal_cnt), 3);

    // Flush while idle blocks the accept.
    ia.flush = 1'b1; ia.op_valid = 1'b1; ia.op = 6'b000001;
    tick();
    chk("a_flush_idle_valid", 32'(ia.ctrl_valid), 0);
    ia.flush = 1'b0;
    qa.push_back(mk(ACC_ALU, 1'b0, 1'b0, cnt_a));
    tick();
    chk("a_after_flush_valid", 32'(ia.ctrl_valid), 1);
    ia.op_valid = 1'b0;
    tick();

    // Flush in the second memory-hold cycle with an op waiting.
    ia.op_valid = 1'b1; ia.op = 6'b001000;
    qa.push_back(mk(ACC_LOAD, 1'b0, 1'b0, cnt_a));
    qa.push_back(mk(ACC_LOAD, 1'b0, 1'b0, cnt_a));
    tick();
    ia.op_valid = 1'b0;
    tick();
    ia.flush = 1'b1; ia.op_valid = 1'b1; ia.op = 6'b100000;
    chk("a_mw2_ready", 32'(ia.op_ready), 0);
    tick();
    ia.flush = 1'b0;
    chk("a_flush_mw_valid", 32'(ia.ctrl_valid), 0);
    chk("a_flush_mw_mem_last", 32'(ia.mem_last), 0);
    chk("a_flush_mw_ready", 32'(ia.op_ready), 1);
    chk("a_flush_cnt_kept", 32'(ia.illegal_cnt), 3);
    qa.push_back(mk(ACC_EQ, 1'b0, 1'b0, cnt_a));
    tick();
    chk("a_post_flush_accept", 32'(ia.ctrl_valid), 1);
    ia.op_valid = 1'b0;

    repeat (3) tick();
    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
